// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings and helpers for mem_arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_WRITE   = 2'd2,
        ST_IO_WAIT = 2'd3
    } state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Address bits 17:16 == 2'b11 select the IO (UART) space.
    localparam int         IO_SEL_HI  = 17;
    localparam int         IO_SEL_LO  = 16;
    localparam logic [1:0] IO_SEL_VAL = 2'b11;

    // Zero-length requests move one byte; oversize requests are cut to the bus width.
    function automatic int clamp_nbytes(input int nb, input int max_nb);
        if (nb == 0) return 1;
        if (nb > max_nb) return max_nb;
        return nb;
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_rr.sv
// rtl/mem_arbiter_arb_rr.sv - fixed-priority / round-robin one-hot grant picker
module mem_arbiter_arb_rr
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int ARB_MODE = ARB_FIXED,
    parameter int IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              adv_i,
    input  logic [NUM_CH-1:0] req_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [IDX_W-1:0]  gnt_idx_o,
    output logic              gnt_valid_o
);

    logic [IDX_W-1:0] ptr_q, ptr_d;

    // Scan from just after the last winner (round-robin) or from channel 0 (fixed).
    always_comb begin
        int start;
        int idx;
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        start       = 0;
        idx         = 0;
        if (ARB_MODE == ARB_RR) begin
            start = int'(ptr_q) + 1;
            if (start >= NUM_CH) start = 0;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            idx = start + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!gnt_valid_o && req_i[idx]) begin
                gnt_valid_o = 1'b1;
                gnt_o[idx]  = 1'b1;
                gnt_idx_o   = IDX_W'(idx);
            end
        end
    end

    // The pointer remembers the last channel actually granted.
    always_comb begin
        ptr_d = ptr_q;
        if (adv_i && gnt_valid_o) ptr_d = gnt_idx_o;
    end

    // Pointer register; starts at the last channel so channel 0 is searched first.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) ptr_q <= IDX_W'(NUM_CH - 1);
        else         ptr_q <= ptr_d;
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - NUM_CH-channel arbiter onto the byte-serial memory/IO bus
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ARB_MODE = 0,
    parameter int NB_W     = $clog2(DATA_W / 8) + 1
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic [NUM_CH-1:0]        req_i,
    input  logic [NUM_CH-1:0]        we_i,
    input  logic [NUM_CH*ADDR_W-1:0] addr_i,
    input  logic [NUM_CH*NB_W-1:0]   nbytes_i,
    input  logic [NUM_CH*DATA_W-1:0] wdata_i,
    input  logic [NUM_CH-1:0]        flush_i,
    output logic [NUM_CH-1:0]        done_o,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     busy_o,
    input  logic [7:0]               mem_din,
    output logic [7:0]               mem_dout,
    output logic [ADDR_W-1:0]        mem_a,
    output logic                     mem_wr,
    input  logic                     io_buffer_full
);

    localparam int MAX_NB = DATA_W / 8;
    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ch_q, ch_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [NB_W-1:0]   n_q, n_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [NB_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] rbuf_q, rbuf_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [NUM_CH-1:0] done_q, done_d;

    logic [NUM_CH-1:0] elig;
    logic [NUM_CH-1:0] gnt;
    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_valid;
    logic [ADDR_W-1:0] win_addr;
    logic [NB_W-1:0]   win_nb;
    logic [DATA_W-1:0] win_wdata;
    logic              win_we;
    logic              win_io;

    // A channel finishing this cycle sits out one arbitration round.
    assign elig = req_i & ~flush_i & ~done_q;

    mem_arbiter_arb_rr #(
        .NUM_CH   (NUM_CH),
        .ARB_MODE (ARB_MODE),
        .IDX_W    (IDX_W)
    ) u_arb (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .adv_i       (rdy_in && (state_q == ST_IDLE)),
        .req_i       (elig),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    assign win_addr  = addr_i[int'(gnt_idx)*ADDR_W +: ADDR_W];
    assign win_nb    = nbytes_i[int'(gnt_idx)*NB_W +: NB_W];
    assign win_wdata = wdata_i[int'(gnt_idx)*DATA_W +: DATA_W];
    assign win_we    = |(we_i & gnt);

    generate
        if (ADDR_W > IO_SEL_HI) begin : g_io
            assign win_io = (win_addr[IO_SEL_HI:IO_SEL_LO] == IO_SEL_VAL);
        end else begin : g_no_io
            assign win_io = 1'b0;
        end
    endgenerate

    // Next-state logic: grant/latch in IDLE, then step one byte per cycle.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        addr_d  = addr_q;
        n_d     = n_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rbuf_d  = rbuf_q;
        rdata_d = rdata_q;
        done_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    ch_d    = gnt_idx;
                    addr_d  = win_addr;
                    n_d     = NB_W'(clamp_nbytes(int'(win_nb), MAX_NB));
                    wdata_d = win_wdata;
                    cnt_d   = '0;
                    rbuf_d  = '0;
                    if (!win_we)                     state_d = ST_READ;
                    else if (win_io && io_buffer_full) state_d = ST_IO_WAIT;
                    else                             state_d = ST_WRITE;
                end
            end
            ST_READ: begin
                if (flush_i[ch_q]) begin
                    state_d = ST_IDLE;
                end else begin
                    // Byte requested last cycle arrives now (1-cycle read latency).
                    if (cnt_q != '0) rbuf_d[int'(cnt_q - NB_W'(1))*8 +: 8] = mem_din;
                    if (cnt_q == n_q) begin
                        rdata_d      = rbuf_d;
                        done_d[ch_q] = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + NB_W'(1);
                    end
                end
            end
            ST_WRITE: begin
                if (cnt_q == n_q - NB_W'(1)) begin
                    done_d[ch_q] = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + NB_W'(1);
                end
            end
            ST_IO_WAIT: begin
                if (!io_buffer_full) begin
                    state_d = ST_WRITE;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus drive: address/data only in active cycles; a stall masks the write strobe.
    always_comb begin
        mem_a    = '0;
        mem_dout = '0;
        mem_wr   = 1'b0;
        case (state_q)
            ST_READ: begin
                if (cnt_q < n_q) mem_a = addr_q + ADDR_W'(cnt_q);
            end
            ST_WRITE: begin
                mem_a    = addr_q + ADDR_W'(cnt_q);
                mem_dout = wdata_q[int'(cnt_q)*8 +: 8];
                mem_wr   = rdy_in;
            end
            default: ;
        endcase
    end

    assign busy_o  = (state_q != ST_IDLE);
    assign done_o  = done_q;
    assign rdata_o = rdata_q;

    // State and datapath registers; everything holds while rdy_in is low.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            addr_q  <= '0;
            n_q     <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rbuf_q  <= '0;
            rdata_q <= '0;
            done_q  <= '0;
        end else if (rdy_in) begin
            state_q <= state_d;
            ch_q    <= ch_d;
            addr_q  <= addr_d;
            n_q     <= n_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rbuf_q  <= rbuf_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic rst_in, rdy_in, io_full;
    int   total = 0;
    int   pass  = 0;

    // Two-channel fixed-priority instance with a memory model behind it
    logic [1:0]  req_a, we_a, flush_a, done_a;
    logic [63:0] addr_a, wdata_a;
    logic [5:0]  nb_a;
    logic [31:0] rdata_a, mem_a_a;
    logic        busy_a, mem_wr_a;
    logic [7:0]  mem_din_a, mem_dout_a;

    // Three-channel instances (round-robin and fixed) sharing one stimulus
    logic [2:0]  req_m, we_m, flush_m, done_rr, done_fx;
    logic [95:0] addr_m, wdata_m;
    logic [8:0]  nb_m;
    logic [31:0] rdata_rr, rdata_fx, mem_a_rr, mem_a_fx;
    logic        busy_rr, busy_fx, mem_wr_rr, mem_wr_fx;
    logic [7:0]  mem_dout_rr, mem_dout_fx;
    logic [7:0]  zero_din = 8'h00;

    logic [7:0] mem [0:1023];

    // Memory shares the global ready, so a stall also holds its output byte.
    always @(posedge clk_in) if (rdy_in) mem_din_a <= mem[mem_a_a[9:0]];

    mem_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .ARB_MODE(0)) dut_a (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .req_i(req_a), .we_i(we_a), .addr_i(addr_a), .nbytes_i(nb_a),
        .wdata_i(wdata_a), .flush_i(flush_a), .done_o(done_a), .rdata_o(rdata_a),
        .busy_o(busy_a), .mem_din(mem_din_a), .mem_dout(mem_dout_a), .mem_a(mem_a_a),
        .mem_wr(mem_wr_a), .io_buffer_full(io_full));

    mem_arbiter #(.NUM_CH(3), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1)) dut_rr (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .req_i(req_m), .we_i(we_m), .addr_i(addr_m), .nbytes_i(nb_m),
        .wdata_i(wdata_m), .flush_i(flush_m), .done_o(done_rr), .rdata_o(rdata_rr),
        .busy_o(busy_rr), .mem_din(zero_din), .mem_dout(mem_dout_rr), .mem_a(mem_a_rr),
        .mem_wr(mem_wr_rr), .io_buffer_full(io_full));

    mem_arbiter #(.NUM_CH(3), .ADDR_W(32), .DATA_W(32), .ARB_MODE(0)) dut_fx (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .req_i(req_m), .we_i(we_m), .addr_i(addr_m), .nbytes_i(nb_m),
        .wdata_i(wdata_m), .flush_i(flush_m), .done_o(done_fx), .rdata_o(rdata_fx),
        .busy_o(busy_fx), .mem_din(zero_din), .mem_dout(mem_dout_fx), .mem_a(mem_a_fx),
        .mem_wr(mem_wr_fx), .io_buffer_full(io_full));

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic int oh2idx(input logic [2:0] v);
        case (v)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return -1;
        endcase
    endfunction

    task automatic test_reset();
        rst_in = 1'b0; rdy_in = 1'b1; io_full = 1'b0;
        req_a = '0; we_a = '0; addr_a = '0; nb_a = '0; wdata_a = '0; flush_a = '0;
        req_m = '0; we_m = '0; addr_m = '0; nb_m = '0; wdata_m = '0; flush_m = '0;
        repeat (2) @(posedge clk_in);
        #1;
        total++; if (busy_a !== 1'b0)   $display("FAIL reset_busy: got %b want 0", busy_a);   else pass++;
        total++; if (done_a !== 2'b00)  $display("FAIL reset_done: got %b want 00", done_a);  else pass++;
        total++; if (rdata_a !== 32'h0) $display("FAIL reset_rdata: got %h want 0", rdata_a); else pass++;
        total++; if (mem_a_a !== 32'h0 || mem_wr_a !== 1'b0 || mem_dout_a !== 8'h0)
            $display("FAIL reset_bus: got a=%h wr=%b dout=%h want 0/0/0", mem_a_a, mem_wr_a, mem_dout_a);
        else pass++;
        rst_in = 1'b1;
    endtask

    task automatic test_read();
        logic [31:0] exp_a;
        logic [1:0]  exp_done;
        req_a = 2'b01; we_a = 2'b00; addr_a[31:0] = 32'h100; nb_a[2:0] = 3'd4;
        for (int c = 1; c <= 7; c++) begin
            tick();
            exp_a    = (c <= 4) ? 32'h100 + 32'(c - 1) : 32'h0;
            exp_done = (c == 6) ? 2'b01 : 2'b00;
            total++; if (mem_a_a !== exp_a) $display("FAIL read_addr c%0d: got %h want %h", c, mem_a_a, exp_a); else pass++;
            total++; if (done_a !== exp_done) $display("FAIL read_done c%0d: got %b want %b", c, done_a, exp_done); else pass++;
            total++; if (busy_a !== (c <= 5)) $display("FAIL read_busy c%0d: got %b want %b", c, busy_a, (c <= 5)); else pass++;
            if (c >= 6) begin
                total++; if (rdata_a !== 32'h11223344) $display("FAIL read_data c%0d: got %h want 11223344", c, rdata_a); else pass++;
            end
            if (c == 6) req_a = 2'b00;
        end
    endtask

    task automatic test_write();
        logic [31:0] exp_a;
        logic [7:0]  exp_d;
        logic [1:0]  exp_done;
        req_a = 2'b10; we_a = 2'b10; addr_a[63:32] = 32'h200; nb_a[5:3] = 3'd2; wdata_a[63:32] = 32'h0000BEEF;
        for (int c = 1; c <= 4; c++) begin
            tick();
            exp_a    = (c <= 2) ? 32'h200 + 32'(c - 1) : 32'h0;
            exp_d    = (c == 1) ? 8'hEF : ((c == 2) ? 8'hBE : 8'h00);
            exp_done = (c == 3) ? 2'b10 : 2'b00;
            total++; if (mem_wr_a !== (c <= 2)) $display("FAIL write_wr c%0d: got %b want %b", c, mem_wr_a, (c <= 2)); else pass++;
            total++; if (mem_a_a !== exp_a) $display("FAIL write_addr c%0d: got %h want %h", c, mem_a_a, exp_a); else pass++;
            total++; if (mem_dout_a !== exp_d) $display("FAIL write_dout c%0d: got %h want %h", c, mem_dout_a, exp_d); else pass++;
            total++; if (done_a !== exp_done) $display("FAIL write_done c%0d: got %b want %b", c, done_a, exp_done); else pass++;
            if (c == 3) begin req_a = 2'b00; we_a = 2'b00; end
        end
    endtask

    task automatic test_flush();
        // ch1 reads 4 bytes and is flushed in cycle 2; ch0 (1-byte read of 0x101) waits behind it
        req_a = 2'b10; we_a = 2'b00; addr_a[63:32] = 32'h100; nb_a[5:3] = 3'd4;
        addr_a[31:0] = 32'h101; nb_a[2:0] = 3'd1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 1) req_a = 2'b11;
            if (c == 2) flush_a = 2'b10;
            if (c == 3) begin flush_a = 2'b00; req_a = 2'b01; end
            #1;
            case (c)
                2: begin
                    total++; if (busy_a !== 1'b1 || mem_a_a !== 32'h101) $display("FAIL flush_pre c2: got busy=%b a=%h want 1/101", busy_a, mem_a_a); else pass++;
                end
                3: begin
                    total++; if (busy_a !== 1'b0) $display("FAIL flush_idle c3: got busy=%b want 0", busy_a); else pass++;
                    total++; if (done_a !== 2'b00) $display("FAIL flush_nodone c3: got %b want 00", done_a); else pass++;
                    total++; if (rdata_a !== 32'h11223344) $display("FAIL flush_rdata_hold c3: got %h want 11223344", rdata_a); else pass++;
                end
                4: begin
                    total++; if (busy_a !== 1'b1 || mem_a_a !== 32'h101) $display("FAIL flush_regrant c4: got busy=%b a=%h want 1/101", busy_a, mem_a_a); else pass++;
                end
                6: begin
                    total++; if (done_a !== 2'b01) $display("FAIL flush_ch0_done c6: got %b want 01", done_a); else pass++;
                    total++; if (rdata_a !== 32'h00000033) $display("FAIL flush_ch0_data c6: got %h want 00000033", rdata_a); else pass++;
                    req_a = 2'b00;
                end
                7: begin
                    total++; if (done_a !== 2'b00) $display("FAIL flush_done_pulse c7: got %b want 00", done_a); else pass++;
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_io_wait();
        logic [31:0] exp_a;
        logic [7:0]  exp_d;
        logic [1:0]  exp_done;
        io_full = 1'b1;
        req_a = 2'b01; we_a = 2'b01; addr_a[31:0] = 32'h0003_0000; nb_a[2:0] = 3'd1; wdata_a[31:0] = 32'h000000A5;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 5) io_full = 1'b0;
            if (c == 2) flush_a = 2'b01;
            if (c == 3) flush_a = 2'b00;
            #1;
            exp_a    = (c == 6) ? 32'h0003_0000 : 32'h0;
            exp_d    = (c == 6) ? 8'hA5 : 8'h00;
            exp_done = (c == 7) ? 2'b01 : 2'b00;
            total++; if (mem_wr_a !== (c == 6)) $display("FAIL io_wr c%0d: got %b want %b", c, mem_wr_a, (c == 6)); else pass++;
            total++; if (mem_a_a !== exp_a || mem_dout_a !== exp_d) $display("FAIL io_bus c%0d: got a=%h d=%h want %h/%h", c, mem_a_a, mem_dout_a, exp_a, exp_d); else pass++;
            total++; if (done_a !== exp_done) $display("FAIL io_done c%0d: got %b want %b", c, done_a, exp_done); else pass++;
            if (c == 7) begin req_a = 2'b00; we_a = 2'b00; end
        end
    endtask

    task automatic test_clamp_wrap();
        logic [31:0] exp_a;
        logic [7:0]  exp_d;
        // nbytes=7 clamps to 4; address wraps past 0xFFFFFFFF
        req_a = 2'b01; we_a = 2'b01; addr_a[31:0] = 32'hFFFF_FFFE; nb_a[2:0] = 3'd7; wdata_a[31:0] = 32'h44332211;
        for (int c = 1; c <= 6; c++) begin
            tick();
            exp_a = (c <= 4) ? 32'hFFFF_FFFE + 32'(c - 1) : 32'h0;
            exp_d = (c <= 4) ? 8'(8'h11 * c) : 8'h00;
            total++; if (mem_a_a !== exp_a || mem_dout_a !== exp_d || mem_wr_a !== (c <= 4))
                $display("FAIL clamp_bus c%0d: got a=%h d=%h wr=%b want %h/%h/%b", c, mem_a_a, mem_dout_a, mem_wr_a, exp_a, exp_d, (c <= 4));
            else pass++;
            total++; if (done_a !== ((c == 5) ? 2'b01 : 2'b00)) $display("FAIL clamp_done c%0d: got %b want %b", c, done_a, (c == 5) ? 2'b01 : 2'b00); else pass++;
            if (c == 5) req_a = 2'b00;
        end
        // nbytes=0 behaves as a single byte
        req_a = 2'b01; addr_a[31:0] = 32'h10; nb_a[2:0] = 3'd0; wdata_a[31:0] = 32'h0000005A;
        for (int c = 1; c <= 3; c++) begin
            tick();
            total++; if (mem_wr_a !== (c == 1)) $display("FAIL zero_nb_wr c%0d: got %b want %b", c, mem_wr_a, (c == 1)); else pass++;
            total++; if (done_a !== ((c == 2) ? 2'b01 : 2'b00)) $display("FAIL zero_nb_done c%0d: got %b want %b", c, done_a, (c == 2) ? 2'b01 : 2'b00); else pass++;
            if (c == 1) begin
                total++; if (mem_a_a !== 32'h10 || mem_dout_a !== 8'h5A) $display("FAIL zero_nb_bus c1: got a=%h d=%h want 10/5a", mem_a_a, mem_dout_a); else pass++;
            end
            if (c == 2) begin req_a = 2'b00; we_a = 2'b00; end
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_a;
        req_a = 2'b01; we_a = 2'b00; addr_a[31:0] = 32'h100; nb_a[2:0] = 3'd4;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 3) rdy_in = 1'b0;
            if (c == 6) rdy_in = 1'b1;
            #1;
            case (c)
                1:       exp_a = 32'h100;
                2:       exp_a = 32'h101;
                3, 4, 5, 6: exp_a = 32'h102;
                7:       exp_a = 32'h103;
                default: exp_a = 32'h0;
            endcase
            total++; if (mem_a_a !== exp_a) $display("FAIL stall_addr c%0d: got %h want %h", c, mem_a_a, exp_a); else pass++;
            total++; if (mem_wr_a !== 1'b0) $display("FAIL stall_wr c%0d: got %b want 0", c, mem_wr_a); else pass++;
            total++; if (done_a !== ((c == 9) ? 2'b01 : 2'b00)) $display("FAIL stall_done c%0d: got %b want %b", c, done_a, (c == 9) ? 2'b01 : 2'b00); else pass++;
            if (c == 9) begin
                total++; if (rdata_a !== 32'h11223344) $display("FAIL stall_data c9: got %h want 11223344", rdata_a); else pass++;
                req_a = 2'b00;
            end
        end
    endtask

    task automatic test_back_to_back();
        int rr_seq[4] = '{-1, -1, -1, -1};
        int fx_seq[4] = '{-1, -1, -1, -1};
        int rr_cyc[4] = '{0, 0, 0, 0};
        int rr_exp[4] = '{0, 1, 2, 0};
        // ch0 takes every fixed arbitration it is eligible for; it sits out only its own done cycle
        int fx_exp[4] = '{0, 1, 0, 1};
        int n_rr = 0;
        int n_fx = 0;
        req_m = 3'b111; we_m = 3'b111; nb_m = {3'd1, 3'd1, 3'd1};
        addr_m = {32'h30, 32'h20, 32'h10}; wdata_m = {32'h3, 32'h2, 32'h1};
        for (int c = 1; c <= 40 && (n_rr < 4 || n_fx < 4); c++) begin
            tick();
            if (done_rr !== 3'b000 && n_rr < 4) begin rr_seq[n_rr] = oh2idx(done_rr); rr_cyc[n_rr] = c; n_rr++; end
            if (done_fx !== 3'b000 && n_fx < 4) begin fx_seq[n_fx] = oh2idx(done_fx); n_fx++; end
        end
        req_m = 3'b000;
        total++; if (n_rr != 4 || n_fx != 4) $display("FAIL arb_timeout: got rr=%0d fx=%0d dones want 4/4", n_rr, n_fx); else pass++;
        for (int i = 0; i < 4; i++) begin
            total++; if (rr_seq[i] != rr_exp[i]) $display("FAIL rr_grant[%0d]: got %0d want %0d", i, rr_seq[i], rr_exp[i]); else pass++;
            total++; if (fx_seq[i] != fx_exp[i]) $display("FAIL fixed_grant[%0d]: got %0d want %0d", i, fx_seq[i], fx_exp[i]); else pass++;
        end
        for (int i = 1; i < 4; i++) begin
            total++; if (rr_cyc[i] - rr_cyc[i-1] != 2) $display("FAIL rr_spacing[%0d]: got %0d want 2", i, rr_cyc[i] - rr_cyc[i-1]); else pass++;
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        req_a = 2'b01; we_a = 2'b00; addr_a[31:0] = 32'h100; nb_a[2:0] = 3'd4;
        tick();
        tick();
        total++; if (mem_a_a !== 32'h101) $display("FAIL rstmid_pre: got %h want 101", mem_a_a); else pass++;
        rst_in = 1'b0;
        #1;
        total++; if (mem_a_a !== 32'h0 || mem_wr_a !== 1'b0 || mem_dout_a !== 8'h0)
            $display("FAIL rstmid_bus: got a=%h wr=%b d=%h want 0/0/0", mem_a_a, mem_wr_a, mem_dout_a);
        else pass++;
        total++; if (busy_a !== 1'b0 || done_a !== 2'b00) $display("FAIL rstmid_ctl: got busy=%b done=%b want 0/00", busy_a, done_a); else pass++;
        total++; if (rdata_a !== 32'h0) $display("FAIL rstmid_rdata: got %h want 0", rdata_a); else pass++;
        req_a = 2'b00;
        tick();
        rst_in = 1'b1;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[256] = 8'h44; mem[257] = 8'h33; mem[258] = 8'h22; mem[259] = 8'h11;
        test_reset();
        test_read();
        test_write();
        test_flush();
        test_io_wait();
        test_clamp_wrap();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
